// File: rtl/fact_seq_engine.sv
// Multi-cycle factorial engine: one RES_W x N_W multiply per clock, valid/ready in and out.
// Optional saturation on first overflowing step when FACT_SAT_EN is defined.
module fact_seq_engine #(
    parameter int unsigned N_W   = 8,
    parameter int unsigned RES_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_W-1:0]   n,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] result,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e             state_q, state_d;
    logic [RES_W-1:0]   acc_q, acc_d;
    logic [N_W-1:0]     cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [RES_W-1:0]   result_q, result_d;
    logic               overflow_q, overflow_d;
    logic               out_valid_q, out_valid_d;

    logic [RES_W+N_W-1:0] prod;
    logic                 step_ovf;

    // Full-width product so the bits above RES_W reveal overflow of this step.
    assign prod     = {{N_W{1'b0}}, acc_q} * {{RES_W{1'b0}}, cnt_q};
    assign step_ovf = |prod[RES_W+N_W-1:RES_W];

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        result_d    = result_q;
        overflow_d  = overflow_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    acc_d   = RES_W'(1);
                    cnt_d   = n;
                    ovf_d   = 1'b0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                if (cnt_q < N_W'(2)) begin
                    result_d    = acc_q;
                    overflow_d  = ovf_q;
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end else begin
`ifdef FACT_SAT_EN
                    if (step_ovf) begin
                        ovf_d       = 1'b1;
                        result_d    = '1;
                        overflow_d  = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = StDone;
                    end else begin
                        acc_d = prod[RES_W-1:0];
                        cnt_d = cnt_q - N_W'(1);
                    end
`else
                    acc_d = prod[RES_W-1:0];
                    ovf_d = ovf_q | step_ovf;
                    cnt_d = cnt_q - N_W'(1);
`endif
                end
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            acc_q       <= RES_W'(1);
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            result_q    <= RES_W'(1);
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_fact_seq_engine.sv
// Scoreboard bench for fact_seq_engine: a 64-bit and a 16-bit instance behind one
// driver/monitor pair, selected by sel.
module tb_fact_seq_engine;

    typedef struct {
        logic [63:0] res;
        logic        ovf;
        int          lat;   // -1: latency not checked
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  n_in = '0;
    logic        out_ready = 1'b1;
    logic        sel = 1'b0;    // 0: 64-bit DUT, 1: 16-bit DUT

    logic        iv64, ir64, ov64, of64, bz64;
    logic [63:0] r64;
    logic        iv16, ir16, ov16, of16, bz16;
    logic [15:0] r16;

    logic        in_ready, out_valid, overflow, busy;
    logic [63:0] result;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    exp_t q[$];
    exp_t cur;
    logic pending = 1'b0;
    logic hs_prev = 1'b0;

    assign iv64 = in_valid & ~sel;
    assign iv16 = in_valid & sel;
    assign in_ready  = sel ? ir16 : ir64;
    assign out_valid = sel ? ov16 : ov64;
    assign overflow  = sel ? of16 : of64;
    assign busy      = sel ? bz16 : bz64;
    assign result    = sel ? {48'b0, r16} : r64;

    fact_seq_engine #(.N_W(8), .RES_W(64)) dut64 (
        .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .n(n_in),
        .out_valid(ov64), .out_ready(out_ready), .result(r64), .overflow(of64), .busy(bz64)
    );

    fact_seq_engine #(.N_W(8), .RES_W(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .n(n_in),
        .out_valid(ov16), .out_ready(out_ready), .result(r16), .overflow(of16), .busy(bz16)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    endtask

    task automatic fail_now(input string nm);
        n_checks++;
        $display("FAIL %s: got timeout expected event", nm);
    endtask

    // Monitor: pops expectations on first cycle of out_valid, then checks hold.
    always @(negedge clk) begin
        if (rst) begin
            pending = 1'b0;
            hs_prev = 1'b0;
        end else begin
            if (hs_prev) begin
                chk("in_ready_after_handshake", {63'b0, in_ready}, 64'd1);
                chk("out_valid_after_handshake", {63'b0, out_valid}, 64'd0);
                hs_prev = 1'b0;
            end
            if (out_valid) begin
                if (!pending) begin
                    if (q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_output: got result %0d expected no output", result);
                        cur.res = result;
                        cur.ovf = overflow;
                        cur.lat = -1;
                    end else begin
                        cur = q.pop_front();
                        chk("result", result, cur.res);
                        chk("overflow", {63'b0, overflow}, {63'b0, cur.ovf});
                        if (cur.lat >= 0)
                            chk("latency", 64'(cyc - acc_cyc), 64'(cur.lat));
                    end
                    pending = 1'b1;
                end else begin
                    chk("result_hold", result, cur.res);
                    chk("overflow_hold", {63'b0, overflow}, {63'b0, cur.ovf});
                end
                chk("in_ready_low_in_done", {63'b0, in_ready}, 64'd0);
                if (out_ready) begin
                    pending = 1'b0;
                    hs_prev = 1'b1;
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input int val, input logic push, input logic [63:0] er,
                        input logic eo, input int el);
        logic done;
        exp_t e;
        done     = 1'b0;
        in_valid = 1'b1;
        n_in     = val[7:0];
        for (int i = 0; i < 100 && !done; i++) begin
            if (in_ready) begin
                if (push) begin
                    e.res = er;
                    e.ovf = eo;
                    e.lat = el;
                    q.push_back(e);
                end
                acc_cyc = cyc + 1;
                done    = 1'b1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!done) fail_now("accept_timeout");
    endtask

    task automatic wait_done();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !pending && !out_valid) done = 1'b1;
        end
        if (!done) fail_now("result_timeout");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_result", result, 64'd1);
        chk("rst_overflow", {63'b0, overflow}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        send(3, 1'b1, 64'd6, 1'b0, 3);                   wait_done();
        send(0, 1'b1, 64'd1, 1'b0, 1);                   wait_done();
        send(1, 1'b1, 64'd1, 1'b0, 1);                   wait_done();
        send(5, 1'b1, 64'd120, 1'b0, 5);                 wait_done();
        send(20, 1'b1, 64'd2432902008176640000, 1'b0, 20); wait_done();
`ifdef FACT_SAT_EN
        send(21, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, -1); wait_done();
`else
        send(21, 1'b1, 64'd14197454024290336768, 1'b1, 21); wait_done();
`endif

        sel = 1'b1;
        @(negedge clk);
        send(8, 1'b1, 64'd40320, 1'b0, 8);               wait_done();
`ifdef FACT_SAT_EN
        send(9, 1'b1, 64'hFFFF, 1'b1, -1);               wait_done();
`else
        send(9, 1'b1, 64'd35200, 1'b1, 9);               wait_done();
`endif
        sel = 1'b0;
        @(negedge clk);

        // Back-pressure: result must hold while in_valid pulses are ignored.
        out_ready = 1'b0;
        send(4, 1'b1, 64'd24, 1'b0, 4);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 50 && !seen; i++) begin
                if (out_valid) seen = 1'b1;
                else @(negedge clk);
            end
            if (!seen) fail_now("backpressure_valid_timeout");
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            n_in     = 8'd7;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_done();

        // Abort n=10 with reset two cycles into the computation.
        send(10, 1'b0, 64'd0, 1'b0, -1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready", {63'b0, in_ready}, 64'd1);
        chk("abort_out_valid", {63'b0, out_valid}, 64'd0);
        chk("abort_busy", {63'b0, busy}, 64'd0);
        chk("abort_result", result, 64'd1);
        chk("abort_overflow", {63'b0, overflow}, 64'd0);
        send(4, 1'b1, 64'd24, 1'b0, 4);                  wait_done();
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
